// File: rtl/pc_fetch.sv
// pc_fetch: program counter / instruction fetch address generator.
// Ports: clk, rst_n (sync, active-low), stall, branch_flag, branch_target,
//   exc_flag in; pc (ROM address), ce (ROM chip enable), addr_err out.
module pc_fetch #(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC   = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]     EXC_VECTOR = ADDR_W'(32'h0000_0020)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              exc_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              addr_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_exc_q, pend_exc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [ADDR_W-1:0] tgt_al;
  logic [ADDR_W-1:0] pc_inc;
  logic              misaligned;

  assign tgt_al     = {branch_target[ADDR_W-1:2], 2'b00};
  assign pc_inc     = pc_q + ADDR_W'(4);
  assign misaligned = |branch_target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = 1'b0;
    pend_v_d   = pend_v_q;
    pend_exc_d = pend_exc_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      // First edge out of reset only raises ce; pc stays at RESET_PC.
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        err_d = branch_flag & misaligned;
        if (stall) begin
          // Exceptions always claim the pending slot; a branch may
          // replace an older branch but never a pending exception.
          if (exc_flag) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b1;
            pend_tgt_d = EXC_VECTOR;
          end else if (branch_flag && !(pend_v_q && pend_exc_q)) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b0;
            pend_tgt_d = tgt_al;
          end
        end else begin
          pend_v_d   = 1'b0;
          pend_exc_d = 1'b0;
          if (exc_flag) begin
            pc_d = EXC_VECTOR;
          end else if (branch_flag) begin
            pc_d = tgt_al;
          end else if (pend_v_q) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_exc_q <= 1'b0;
      pend_tgt_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      pend_v_q   <= pend_v_d;
      pend_exc_q <= pend_exc_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = (state_q == ST_RUN);
  assign addr_err = err_q;

endmodule
